if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the operand-fetch stage. Drives IF_PC / IF_instruction, which operand fetch samples on posedge clk2 when its stall is low.
- Owns the fetch PC and a pipelined request/grant/rvalid handshake to instruction memory.
- Buffers in-order responses in a small prefetch FIFO so fetch continues while the pipe is stalled.
- Handles branch redirect by dropping stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, prefetch entries; power of 2, at least 2. Also the cap on (occupancy + outstanding).
- NOP_INSTR, 32'h0000_0013, addi x0,x0,0. Issued on bubbles and after reset.

Ports:
- clk2  in  1  pipeline clock; all state updates on its posedge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard stall; holds IF_* outputs and blocks FIFO pop.
- branch_taken  in  1  redirect request from execute; one-cycle pulse.
- branch_target  in  32  redirect address; bits [1:0] forced to 0.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address; equals fetch_pc.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid. Responses are in order, at least 1 cycle after grant.
- imem_rdata  in  32  response instruction.
- IF_PC  out  32  PC of the presented instruction.
- IF_instruction  out  32  instruction presented to operand fetch.
- IF_valid  out  1  1 = real instruction, 0 = bubble (IF_instruction = NOP_INSTR).

Behaviour:
- Reset (async):
  - fetch_pc = RESET_PC; FIFO empty; outstanding = 0; drop_cnt = 0; state = IDLE.
  - IF_PC = 0; IF_instruction = NOP_INSTR; IF_valid = 0; imem_req = 0.
  - Reset asserted mid-operation discards everything; later rvalids for pre-reset requests are the memory's responsibility and are not expected.
- States:
  - IDLE -> FETCH on the first clk2 edge after reset release.
  - FETCH -> DRAIN on branch_taken when outstanding (after this cycle's updates) > 0.
  - FETCH stays in FETCH on branch_taken when nothing is outstanding.
  - DRAIN -> FETCH when drop_cnt reaches 0. A branch_taken in DRAIN reloads fetch_pc and stays in DRAIN.
- Request rule: imem_req = (state == FETCH) && (occupancy + outstanding < FIFO_DEPTH) && !branch_taken. This is combinational from registers plus branch_taken.
- On req && gnt: fetch_pc += 4 (wraps modulo 2^32); outstanding += 1.
- On rvalid: outstanding -= 1.
  - If drop_cnt > 0: discard the response and decrement drop_cnt.
  - Otherwise, if ~stall and the FIFO is empty: bypass straight into the IF_* registers with IF_valid = 1. PC is taken from the pc-tag queue.
  - Otherwise: push {pc, rdata} into the FIFO. Space is guaranteed by the request rule.
- Pc-tag queue: the PC of each granted request is recorded in a depth-FIFO_DEPTH tag queue, popped on rvalid.
- Output update when ~stall and no redirect:
  - FIFO non-empty: pop the head into IF_*, IF_valid = 1.
  - FIFO empty and no usable rvalid: IF_instruction = NOP_INSTR, IF_valid = 0, IF_PC unchanged.
- stall = 1: IF_* hold. Pushes still occur; pops do not.
- Redirect (branch_taken at an edge) has priority over stall and everything else:
  - fetch_pc = {branch_target[31:2], 2'b00}; FIFO and tag queue cleared.
  - drop_cnt = outstanding after this cycle's grant/rvalid accounting.
  - IF_instruction = NOP_INSTR, IF_valid = 0.
  - An rvalid in the redirect cycle is dropped.
- Latency: with 1-cycle memory and no stall, the instruction is on IF_* 2 edges after its grant edge (1 via bypass, plus the grant edge). Throughput is 1 instruction per cycle at steady state.
- Simultaneous push and pop in the same cycle: occupancy is unchanged.

Decomposition:
- Shared constants (package / constants include): NOP_INSTR value and the fetch state encodings IDLE / FETCH / DRAIN.
- One natural sub-module: fetch_fifo. It is a parameterised synchronous FIFO with async reset, clear, push, pop, full, empty, and count outputs. It is instantiated twice: once as the 64-bit prefetch buffer and once as the 32-bit pc-tag queue.

Test Plan:
- Reset release, 1-cycle memory, gnt = 1 always -> IF_PC = 0, 4, 8 on consecutive edges starting 2 edges after the first grant; IF_valid = 1.
- Stall held for 3 cycles after IF_PC = 4 -> IF_* frozen at PC 4. Afterwards PC 8 and 12 appear on consecutive edges from the FIFO. imem_req drops once occupancy + outstanding = 2.
- branch_taken with target 0x103 and 2 responses outstanding -> both responses dropped, state passes through DRAIN. imem_addr = 0x100; the next valid IF_PC is 0x100. IF_valid = 0 in between.
- branch_taken and stall both high on the same edge -> IF_instruction = 0x00000013, IF_valid = 0, and the redirect proceeds.
- imem_gnt low for 4 cycles -> fetch_pc held, imem_req stays high, IF_valid = 0 bubbles, no PC skipped.
- fetch_pc = 0xFFFFFFFC granted -> next imem_addr = 0x00000000 (wrap).

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage: bubble encoding and fetch FSM states.
package if_fetch_stage_pkg;

  localparam logic [31:0] NopInstrDefault = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_fetch_fifo.sv
// Synchronous FIFO with async reset and synchronous clear; used for prefetch data and PC tags.
module if_fetch_stage_fetch_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [Width-1:0]           wdata,
  input  logic                       pop,
  output logic [Width-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth+1)-1:0] count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns fetch PC, pipelined req/gnt/rvalid imem handshake, prefetch buffering
// and redirect handling that drops responses still in flight at the time of a branch.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = NopInstrDefault
) (
  input  logic        clk2,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_instruction,
  output logic        IF_valid
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SumW = CntW + 1;

  fetch_state_e    state_q;
  logic [31:0]     fetch_pc_q;
  logic [CntW-1:0] outstanding_q;
  logic [CntW-1:0] drop_cnt_q;

  logic [CntW-1:0] outstanding_nxt;
  logic [CntW-1:0] drop_nxt;
  logic [SumW-1:0] occ_sum;
  logic            grant;
  logic            drop_dec;
  logic            resp_keep;
  logic            resp_use;
  logic            bypass;

  logic            buf_push;
  logic            buf_pop;
  logic [63:0]     buf_rdata;
  logic            buf_full;
  logic            buf_empty;
  logic [CntW-1:0] buf_count;

  logic [31:0]     tag_rdata;
  logic            tag_full;
  logic            tag_empty;
  logic [CntW-1:0] tag_count;
  logic            unused_ok;

  // Buffered entries plus requests in flight never exceed the buffer depth, so every
  // response that cannot bypass is guaranteed a slot.
  assign occ_sum   = SumW'(buf_count) + SumW'(outstanding_q);
  assign imem_req  = (state_q == StFetch) && (occ_sum < SumW'(FIFO_DEPTH)) && !branch_taken;
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;

  assign outstanding_nxt = outstanding_q + CntW'(grant) - CntW'(imem_rvalid);
  assign drop_dec        = imem_rvalid && (drop_cnt_q != '0);
  assign drop_nxt        = drop_cnt_q - CntW'(drop_dec);

  assign resp_keep = imem_rvalid && (drop_cnt_q == '0);
  assign resp_use  = resp_keep && !branch_taken;
  assign bypass    = resp_use && !stall && buf_empty;
  assign buf_push  = resp_use && !bypass;
  assign buf_pop   = !branch_taken && !stall && !buf_empty;

  if_fetch_stage_fetch_fifo #(
    .Width (64),
    .Depth (FIFO_DEPTH)
  ) u_prefetch_buf (
    .clk   (clk2),
    .rst   (rst),
    .clear (branch_taken),
    .push  (buf_push),
    .wdata ({tag_rdata, imem_rdata}),
    .pop   (buf_pop),
    .rdata (buf_rdata),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  // Tags are only consumed by responses that are kept; dropped ones belong to a flushed stream.
  if_fetch_stage_fetch_fifo #(
    .Width (32),
    .Depth (FIFO_DEPTH)
  ) u_pc_tags (
    .clk   (clk2),
    .rst   (rst),
    .clear (branch_taken),
    .push  (grant),
    .wdata (fetch_pc_q),
    .pop   (resp_keep),
    .rdata (tag_rdata),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  assign unused_ok = ^{buf_full, tag_full, tag_empty, tag_count, branch_target[1:0]};

  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      fetch_pc_q     <= RESET_PC;
      outstanding_q  <= '0;
      drop_cnt_q     <= '0;
      IF_PC          <= '0;
      IF_instruction <= NOP_INSTR;
      IF_valid       <= 1'b0;
    end else begin
      outstanding_q <= outstanding_nxt;
      if (grant) fetch_pc_q <= fetch_pc_q + 32'd4;

      if (branch_taken) begin
        fetch_pc_q     <= {branch_target[31:2], 2'b00};
        drop_cnt_q     <= outstanding_nxt;
        IF_instruction <= NOP_INSTR;
        IF_valid       <= 1'b0;
      end else begin
        drop_cnt_q <= drop_nxt;
        if (!stall) begin
          if (!buf_empty) begin
            {IF_PC, IF_instruction} <= buf_rdata;
            IF_valid                <= 1'b1;
          end else if (bypass) begin
            IF_PC          <= tag_rdata;
            IF_instruction <= imem_rdata;
            IF_valid       <= 1'b1;
          end else begin
            IF_instruction <= NOP_INSTR;
            IF_valid       <= 1'b0;
          end
        end
      end

      unique case (state_q)
        StIdle:  state_q <= StFetch;
        StFetch: if (branch_taken && (outstanding_nxt != '0)) state_q <= StDrain;
        StDrain: if (!branch_taken && (drop_nxt == '0)) state_q <= StFetch;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: in-order memory responder plus a queue-based reference model.
module tb_if_fetch_stage;

  localparam int          Depth = 2;
  localparam logic [31:0] Nop   = 32'h0000_0013;

  logic        clk2 = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] IF_PC;
  logic [31:0] IF_instruction;
  logic        IF_valid;

  always #5 clk2 = ~clk2;

  if_fetch_stage dut (
    .clk2           (clk2),
    .rst            (rst),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .IF_PC          (IF_PC),
    .IF_instruction (IF_instruction),
    .IF_valid       (IF_valid)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Memory: granted addresses answered in order; mem_hold delays all responses.
  logic [31:0] mem_q [$];
  logic        mem_hold = 1'b0;

  // Reference model. m_state: 0 idle, 1 fetching, 2 draining.
  int          m_state = 0;
  logic [31:0] m_pc    = 32'h0;
  int          m_out   = 0;
  int          m_drop  = 0;
  logic [63:0] m_fifo [$];
  logic [31:0] m_tags [$];
  logic [31:0] m_if_pc    = 32'h0;
  logic [31:0] m_if_instr = Nop;
  logic        m_if_valid = 1'b0;

  logic        last_req;
  logic [31:0] last_gnt_addr;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h5A5A_0000 ^ {a[15:0], 16'h0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc(input logic s, input logic b, input logic [31:0] t, input logic g);
    logic        rv;
    logic [31:0] raddr;
    logic [31:0] rd;
    logic        req;
    logic        got;
    logic [63:0] entry;
    int          out_n;
    stall = s; branch_taken = b; branch_target = t; imem_gnt = g;
    rv = 1'b0; raddr = 32'h0;
    if (!mem_hold && mem_q.size() > 0) begin
      rv    = 1'b1;
      raddr = mem_q.pop_front();
    end
    rd          = rv ? mem_data(raddr) : 32'h0;
    imem_rvalid = rv;
    imem_rdata  = rd;
    #1;
    req = (m_state == 1) && (m_fifo.size() + m_out < Depth) && !b;
    chk("imem_req", 32'(imem_req), 32'(req));
    chk("imem_addr", imem_addr, m_pc);
    last_req = imem_req;
    if (req && g) begin
      mem_q.push_back(m_pc);
      last_gnt_addr = m_pc;
    end
    out_n = m_out + int'(req && g) - int'(rv);
    if (b) begin
      m_if_instr = Nop;
      m_if_valid = 1'b0;
      m_fifo.delete();
      m_tags.delete();
      m_drop = out_n;
      m_pc   = {t[31:2], 2'b00};
      if (m_state == 0) m_state = 1;
      else if (m_state == 1 && out_n > 0) m_state = 2;
    end else begin
      got = 1'b0; entry = 64'h0;
      if (rv) begin
        if (m_drop > 0) m_drop--;
        else begin
          entry = {m_tags.pop_front(), rd};
          got   = 1'b1;
        end
      end
      if (req && g) begin
        m_tags.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
      if (!s) begin
        if (m_fifo.size() > 0) begin
          {m_if_pc, m_if_instr} = m_fifo.pop_front();
          m_if_valid = 1'b1;
          if (got) m_fifo.push_back(entry);
        end else if (got) begin
          {m_if_pc, m_if_instr} = entry;
          m_if_valid = 1'b1;
        end else begin
          m_if_instr = Nop;
          m_if_valid = 1'b0;
        end
      end else if (got) begin
        m_fifo.push_back(entry);
      end
      if (m_state == 0) m_state = 1;
      else if (m_state == 2 && m_drop == 0) m_state = 1;
    end
    m_out = out_n;
    @(negedge clk2);
    chk("if_pc", IF_PC, m_if_pc);
    chk("if_instruction", IF_instruction, m_if_instr);
    chk("if_valid", 32'(IF_valid), 32'(m_if_valid));
  endtask

  task automatic run_until_valid(input string name, input logic [31:0] exp_pc);
    logic seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      seen = IF_valid;
    end
    chk({name, "_seen"}, 32'(seen), 32'h1);
    if (seen) chk(name, IF_PC, exp_pc);
  endtask

  initial begin
    logic found;
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    last_req = 1'b0; last_gnt_addr = 32'h0;
    repeat (2) @(negedge clk2);
    chk("rst_if_pc", IF_PC, 32'h0);
    chk("rst_if_instr", IF_instruction, Nop);
    chk("rst_if_valid", 32'(IF_valid), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    rst = 1'b0;

    // Streaming with a 1-cycle memory.
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("seq_pc0", IF_PC, 32'h0);
    chk("seq_valid0", 32'(IF_valid), 32'h1);
    chk("seq_instr0", IF_instruction, 32'h5A5A_0000);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("seq_pc4", IF_PC, 32'h4);

    // Stall for three cycles while prefetch fills.
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    chk("stall_req_cap", 32'(last_req), 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    chk("stall_hold_pc", IF_PC, 32'h4);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("unstall_pc8", IF_PC, 32'h8);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("unstall_pc12", IF_PC, 32'hC);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("unstall_pc16", IF_PC, 32'h10);

    // Grant withheld for four cycles.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk("nogrant_req", 32'(last_req), 32'h1);
    end
    chk("nogrant_addr_held", imem_addr, 32'h18);
    chk("nogrant_bubble", 32'(IF_valid), 32'h0);
    run_until_valid("nogrant_resume", 32'h18);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect with two responses in flight.
    mem_hold = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("hold_req_cap", 32'(last_req), 32'h0);
    cyc(1'b0, 1'b1, 32'h0000_0103, 1'b1);
    chk("br_addr", imem_addr, 32'h100);
    chk("br_bubble_instr", IF_instruction, Nop);
    chk("br_bubble_valid", 32'(IF_valid), 32'h0);
    mem_hold = 1'b0;
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("drain_no_req", 32'(last_req), 32'h0);
    run_until_valid("br_first_pc", 32'h100);

    // Redirect and stall on the same edge.
    cyc(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    chk("brstall_instr", IF_instruction, Nop);
    chk("brstall_valid", 32'(IF_valid), 32'h0);
    chk("brstall_addr", imem_addr, 32'h200);
    run_until_valid("brstall_first_pc", 32'h200);

    // Address wrap at the top of the space.
    cyc(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      found = (last_gnt_addr == 32'hFFFF_FFFC);
    end
    chk("wrap_granted", 32'(found), 32'h1);
    chk("wrap_addr", imem_addr, 32'h0);
    run_until_valid("wrap_top_pc", 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_next_pc", IF_PC, 32'h0);
    repeat (4) cyc(1'b0, 1'b0, 32'h0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
